// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// controller state, and the register-match helper.
package pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_e;

   // True when a stage writing register rw will produce register r; r0 never matches.
   function automatic logic reg_match(input logic [4:0] r,
                                      input logic       wr,
                                      input logic [4:0] rw);
      return wr && (rw == r) && (r != REG_ZERO);
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts up on inc, holds at all-ones, async active-low clear.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Increment while below all-ones, otherwise hold.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stalls on RAW/load-use hazards, flushes on
// taken branches, drives EX forwarding selects, counts stall/flush events.
// Build option FWD_EN: operand forwarding present, only load-use stalls.
//
// state | meaning
// RUN   | normal issue; hazard check active
// STALL | multi-cycle stall in progress; scnt cycles remain
import pipe_pkg::*;

module hazard_ctrl #(
   parameter int CNT_W     = 16,
   parameter int MAX_STALL = 2
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic [4:0]       ex_Rw,
   input  logic             ex_RegWr,
   input  logic             ex_MemtoReg,
   input  logic [4:0]       mem_Rw,
   input  logic             mem_RegWr,
   input  logic             mem_Branch,
   input  logic             mem_zero,
   input  logic [4:0]       wb_Rw,
   input  logic             wb_RegWr,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic [1:0]       fwdA,
   output logic [1:0]       fwdB,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int SC_W = $clog2(MAX_STALL + 1);

   state_e          state_q, state_d;
   logic [SC_W-1:0] scnt_q, scnt_d;
   logic            branch;
   logic            hit_ex;
   logic            hazard;
   logic [SC_W-1:0] stall_len;
   logic [1:0]      fwd_a, fwd_b;

`ifndef FWD_EN
   logic hit_mem;
   logic unused_fwd;
   assign unused_fwd = ^{ex_MemtoReg, ex_rs, ex_rt, wb_Rw, wb_RegWr};
`endif

   // Hazard detection and stall length; without forwarding, an ex match needs one extra cycle.
   always_comb begin
      branch = mem_Branch & mem_zero;
      hit_ex = (id_use_rs & reg_match(id_rs, ex_RegWr, ex_Rw)) |
               (id_use_rt & reg_match(id_rt, ex_RegWr, ex_Rw));
`ifdef FWD_EN
      hazard    = ex_MemtoReg & hit_ex;
      stall_len = '0;
      fwd_a = reg_match(ex_rs, mem_RegWr, mem_Rw) ? FWD_MEM :
              reg_match(ex_rs, wb_RegWr, wb_Rw)   ? FWD_WB  : FWD_RF;
      fwd_b = reg_match(ex_rt, mem_RegWr, mem_Rw) ? FWD_MEM :
              reg_match(ex_rt, wb_RegWr, wb_Rw)   ? FWD_WB  : FWD_RF;
`else
      hit_mem = (id_use_rs & reg_match(id_rs, mem_RegWr, mem_Rw)) |
                (id_use_rt & reg_match(id_rt, mem_RegWr, mem_Rw));
      hazard    = hit_ex | hit_mem;
      stall_len = hit_ex ? SC_W'(1) : '0;
      fwd_a     = FWD_RF;
      fwd_b     = FWD_RF;
`endif
   end

   // Next state and combinational enables/flushes; branch overrides everything.
   always_comb begin
      state_d     = state_q;
      scnt_d      = scnt_q;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      fwdA        = fwd_a;
      fwdB        = fwd_b;
      if (branch) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         state_d     = RUN;
         scnt_d      = '0;
      end else if (state_q == STALL) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
         scnt_d     = scnt_q - SC_W'(1);
         if (scnt_q == SC_W'(1))
            state_d = RUN;
      end else if (hazard) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
         if (stall_len != '0) begin
            scnt_d  = stall_len;
            state_d = STALL;
         end
      end
      if (!clr) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         fwdA        = FWD_RF;
         fwdB        = FWD_RF;
      end
   end

   // State and stall counter registers.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= RUN;
         scnt_q  <= '0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (clr),
      .inc   (~pc_en),
      .count (stall_cycles)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clr   (clr),
      .inc   (branch),
      .count (flush_events)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_hazard_ctrl;

   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          clr;
   logic [4:0]    id_rs, id_rt, ex_rs, ex_rt, ex_Rw, mem_Rw, wb_Rw;
   logic          id_use_rs, id_use_rt, ex_RegWr, ex_MemtoReg;
   logic          mem_RegWr, mem_Branch, mem_zero, wb_RegWr;
   logic          pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush;
   logic [1:0]    fwdA, fwdB;
   logic [CW-1:0] stall_cycles, flush_events;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   int stall_left = 0;
   int m_stall    = 0;
   int m_flush    = 0;

   hazard_ctrl #(.CNT_W(CW), .MAX_STALL(2)) dut (
      .clk(clk), .clr(clr),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_Rw(ex_Rw), .ex_RegWr(ex_RegWr),
      .ex_MemtoReg(ex_MemtoReg),
      .mem_Rw(mem_Rw), .mem_RegWr(mem_RegWr), .mem_Branch(mem_Branch),
      .mem_zero(mem_zero),
      .wb_Rw(wb_Rw), .wb_RegWr(wb_RegWr),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .fwdA(fwdA), .fwdB(fwdB),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit writes(input logic [4:0] r, input logic wr, input logic [4:0] rw);
      return wr && (rw == r) && (r != 5'd0);
   endfunction

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic idle();
      id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
      ex_rs = 0; ex_rt = 0; ex_Rw = 0; ex_RegWr = 0; ex_MemtoReg = 0;
      mem_Rw = 0; mem_RegWr = 0; mem_Branch = 0; mem_zero = 0;
      wb_Rw = 0; wb_RegWr = 0;
   endtask

   // Called just after a falling edge with inputs set: checks all outputs
   // against the model, advances the model at the rising edge, returns at the
   // next falling edge.
   task automatic cycle();
      bit br, ex_hit, mem_hit, haz, stalling;
      int len;
      int ea, eb;
      #1;
      br      = mem_Branch && mem_zero;
      ex_hit  = (id_use_rs && writes(id_rs, ex_RegWr, ex_Rw)) ||
                (id_use_rt && writes(id_rt, ex_RegWr, ex_Rw));
      mem_hit = (id_use_rs && writes(id_rs, mem_RegWr, mem_Rw)) ||
                (id_use_rt && writes(id_rt, mem_RegWr, mem_Rw));
`ifdef FWD_EN
      haz = ex_MemtoReg && ex_hit;
      len = 0;
      ea  = writes(ex_rs, mem_RegWr, mem_Rw) ? 2 : writes(ex_rs, wb_RegWr, wb_Rw) ? 1 : 0;
      eb  = writes(ex_rt, mem_RegWr, mem_Rw) ? 2 : writes(ex_rt, wb_RegWr, wb_Rw) ? 1 : 0;
`else
      haz = ex_hit || mem_hit;
      len = ex_hit ? 1 : 0;
      ea  = 0;
      eb  = 0;
`endif
      stalling = !br && (stall_left > 0 || haz);
      chk("pc_en",        pc_en,        !stalling);
      chk("ifid_en",      ifid_en,      !stalling);
      chk("ifid_flush",   ifid_flush,   br);
      chk("idex_flush",   idex_flush,   br || stalling);
      chk("exmem_flush",  exmem_flush,  br);
      chk("fwdA",         fwdA,         ea);
      chk("fwdB",         fwdB,         eb);
      chk("stall_cycles", stall_cycles, m_stall);
      chk("flush_events", flush_events, m_flush);
      @(posedge clk);
      if (br) begin
         stall_left = 0;
         m_flush    = sat(m_flush + 1);
      end else if (stall_left > 0) begin
         stall_left--;
      end else if (haz) begin
         stall_left = len;
      end
      if (stalling) m_stall = sat(m_stall + 1);
      @(negedge clk);
   endtask

   initial begin
      idle();
      clr = 1'b0;
      // reset held for three cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("rst_pc_en",       pc_en,       0);
         chk("rst_ifid_en",     ifid_en,     0);
         chk("rst_flushes",     {ifid_flush, idex_flush, exmem_flush}, 7);
         chk("rst_fwd",         {fwdA, fwdB}, 0);
         chk("rst_stall_cnt",   stall_cycles, 0);
      end
      @(negedge clk);
      clr = 1'b1;
      #1;
      chk("post_rst_pc_en",  pc_en, 1);
      chk("post_rst_flush",  {ifid_flush, idex_flush, exmem_flush}, 0);
      cycle();
      chk("post_rst_counts", stall_cycles + flush_events, 0);

`ifdef FWD_EN
      // load-use: exactly one stall cycle
      ex_MemtoReg = 1; ex_RegWr = 1; ex_Rw = 8; id_rs = 8; id_use_rs = 1;
      #1 chk("lu_pc_en", pc_en, 0);
      chk("lu_idex_flush", idex_flush, 1);
      cycle();
      idle();
      #1 chk("lu_resume", pc_en, 1);
      cycle();
      chk("lu_stall_cnt", stall_cycles, 1);
      // forwarding priority
      ex_rs = 5; mem_Rw = 5; wb_Rw = 5; mem_RegWr = 1; wb_RegWr = 1;
      #1 chk("fwd_mem", fwdA, 2);
      cycle();
      mem_RegWr = 0;
      #1 chk("fwd_wb", fwdA, 1);
      cycle();
      ex_rs = 0;
      #1 chk("fwd_r0", fwdA, 0);
      cycle();
      idle();
      mem_Branch = 1; mem_zero = 1;
      cycle();
      idle();
      cycle();
      chk("br_flush_cnt", flush_events, 1);
`else
      // ex match: two stall cycles
      ex_Rw = 3; ex_RegWr = 1; id_rt = 3; id_use_rt = 1;
      #1 chk("raw_ex_c1", pc_en, 0);
      cycle();
      idle();
      #1 chk("raw_ex_c2", pc_en, 0);
      cycle();
      #1 chk("raw_ex_done", pc_en, 1);
      cycle();
      chk("raw_ex_cnt", stall_cycles, 2);
      // mem match: one stall cycle
      mem_Rw = 3; mem_RegWr = 1; id_rt = 3; id_use_rt = 1;
      #1 chk("raw_mem_c1", pc_en, 0);
      cycle();
      idle();
      #1 chk("raw_mem_done", pc_en, 1);
      cycle();
      chk("raw_mem_cnt", stall_cycles, 3);
      // branch aborts an in-progress stall on its second cycle
      ex_Rw = 7; ex_RegWr = 1; id_rs = 7; id_use_rs = 1;
      cycle();
      idle();
      mem_Branch = 1; mem_zero = 1;
      #1 chk("abort_pc_en", pc_en, 1);
      chk("abort_flushes", {ifid_flush, idex_flush, exmem_flush}, 7);
      cycle();
      idle();
      #1 chk("abort_run", pc_en, 1);
      cycle();
      chk("abort_flush_cnt", flush_events, 1);
      chk("abort_stall_cnt", stall_cycles, 4);
`endif

      // saturation: continuous hazard for more than 2^CW cycles
      ex_MemtoReg = 1; ex_RegWr = 1; ex_Rw = 8; id_rs = 8; id_use_rs = 1;
      for (int i = 0; i < (1 << CW) + 5; i++) cycle();
      chk("sat_stall_cnt", stall_cycles, 15);
      idle();
      cycle();

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
         ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
         ex_Rw = 5'($urandom_range(0, 3)); mem_Rw = 5'($urandom_range(0, 3));
         wb_Rw = 5'($urandom_range(0, 3));
         id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
         ex_RegWr = 1'($urandom); ex_MemtoReg = 1'($urandom);
         mem_RegWr = 1'($urandom); wb_RegWr = 1'($urandom);
         mem_Branch = ($urandom_range(0, 3) == 0); mem_zero = 1'($urandom);
         if (i == 1000) begin
            // asynchronous reset mid-run clears counters and any stall
            clr = 1'b0;
            #1 chk("mid_rst_pc_en", pc_en, 0);
            chk("mid_rst_cnt", stall_cycles + flush_events, 0);
            @(negedge clk);
            clr = 1'b1;
            stall_left = 0; m_stall = 0; m_flush = 0;
         end
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
